bist_tester: RTL and testbench



---
 rtl/bist_tester.sv | 165 ++++++++++++++++
 tb/tb_bist_tester.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bist_tester.sv
// LFSR-driven pattern source and MISR response compactor for checking a
// circuit under test against a golden signature in simulation.
module bist_tester #(
  parameter int          PI_W   = 4,
  parameter int          PO_W   = 1,
  parameter int          NPAT   = 255,
  parameter int          FLUSH  = 4,
  parameter int          LAT    = 1,
  parameter logic [7:0]  SEED   = 8'h01,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic            CK,
  input  logic            RSTN,
  input  logic            START,
  input  logic [PO_W-1:0] PO,
  output logic [PI_W-1:0] PI,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [15:0]     SIG
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [16:0] FLUSH_END = 17'(FLUSH - 1);
  localparam logic [16:0] RUN_END   = 17'(NPAT - 1);
  localparam logic [16:0] DRAIN_END = 17'(NPAT + LAT - 1);
  localparam logic [17:0] LAT_W     = 18'(LAT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [16:0]       r_cnt;
  logic [7:0]        r_lfsr;
  logic [PI_W-1:0]   r_pi;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [15:0]       r_sig;

  logic              w_start;
  logic              w_cap;
  logic [7:0]        w_lfsr_cur;
  logic [7:0]        w_lfsr_step;
  logic [15:0]       w_po_ext;
  logic [15:0]       w_misr;
  logic [16:0]       w_cnt_nxt;
  logic [7:0]        w_lfsr_nxt;
  logic [PI_W-1:0]   w_pi_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_pass_nxt;
  logic [15:0]       w_sig_nxt;

  // START only counts when no run is in progress
  assign w_start = START && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) w_state_nxt = (FLUSH == 0) ? S_RUN : S_INIT;
        else       w_state_nxt = r_state;
      end
      S_INIT: begin
        if (r_cnt == FLUSH_END) w_state_nxt = S_RUN;
        else                    w_state_nxt = S_INIT;
      end
      S_RUN: begin
        if (r_cnt == RUN_END) w_state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
        else                  w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_END) w_state_nxt = S_DONE;
        else                    w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_cnt counts cycles from the first RUN cycle through DRAIN, so capture
  // starts once it reaches LAT (written as cnt+1 > LAT to stay valid for LAT=0).
  always_comb begin
    w_lfsr_cur  = w_start ? SEED_EFF : r_lfsr;
    w_lfsr_step = {w_lfsr_cur[6:0],
                   w_lfsr_cur[7] ^ w_lfsr_cur[5] ^ w_lfsr_cur[4] ^ w_lfsr_cur[3]};
    w_po_ext    = 16'(PO);
    w_misr      = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ w_po_ext;
    w_cap       = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                  (({1'b0, r_cnt} + 18'd1) > LAT_W);

    w_cnt_nxt = r_cnt;
    if (w_start) begin
      w_cnt_nxt = 17'd0;
    end else begin
      case (r_state)
        S_INIT:         w_cnt_nxt = (r_cnt == FLUSH_END) ? 17'd0 : r_cnt + 17'd1;
        S_RUN, S_DRAIN: w_cnt_nxt = r_cnt + 17'd1;
        default:        w_cnt_nxt = r_cnt;
      endcase
    end

    if (w_state_nxt == S_RUN) begin
      w_pi_nxt   = w_lfsr_cur[PI_W-1:0];
      w_lfsr_nxt = w_lfsr_step;
    end else begin
      w_pi_nxt   = '0;
      w_lfsr_nxt = w_lfsr_cur;
    end

    w_sig_nxt  = w_start ? 16'h0000 : (w_cap ? w_misr : r_sig);
    w_busy_nxt = (w_state_nxt == S_INIT) || (w_state_nxt == S_RUN) ||
                 (w_state_nxt == S_DRAIN);
    w_done_nxt = (w_state_nxt == S_DONE);

    if (w_start) begin
      w_pass_nxt = 1'b0;
    end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      w_pass_nxt = (w_sig_nxt == GOLDEN);
    end else begin
      w_pass_nxt = r_pass;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt  <= 17'd0;
      r_lfsr <= SEED_EFF;
      r_pi   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_sig  <= 16'h0000;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_lfsr <= w_lfsr_nxt;
      r_pi   <= w_pi_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
      r_sig  <= w_sig_nxt;
    end
  end

  assign PI   = r_pi;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign SIG  = r_sig;

endmodule

// File: tb/tb_bist_tester.sv
// Scoreboard bench: three bist_tester configurations share START/PO; per-cycle
// expectations are queued by the stimulus and checked by a negedge monitor.
module tb_bist_tester;

  typedef struct {
    logic [7:0]  pi;
    logic        busy;
    logic        done;
    logic        pass;
    logic        chk_sig;
    logic [15:0] sig;
  } exp_t;

  typedef struct {
    int   id;
    exp_t a;
    exp_t b;
    exp_t c;
  } ent_t;

  logic ck = 1'b0;
  logic rstn;
  logic start;
  logic [0:0] po;

  logic [3:0]  pi_a, pi_b;
  logic [7:0]  pi_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;

  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_id = 0;

  // Hand-derived PI sequences per cycle after the START edge
  logic [7:0] tab_a [0:8]  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h03, 8'h00};
  logic [7:0] tab_b [0:6]  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h00};
  logic [7:0] tab_c [0:17] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C,
                               8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25, 8'h4B, 8'h97};

  always #5 ck = ~ck;

  bist_tester #(.PI_W(4), .PO_W(1), .NPAT(6), .FLUSH(2), .LAT(1),
                .SEED(8'h01), .GOLDEN(16'h003F)) u_dut_a (
    .CK(ck), .RSTN(rstn), .START(start), .PO(po),
    .PI(pi_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a));

  bist_tester #(.PI_W(4), .PO_W(1), .NPAT(4), .FLUSH(2), .LAT(1),
                .SEED(8'h01), .GOLDEN(16'h000F)) u_dut_b (
    .CK(ck), .RSTN(rstn), .START(start), .PO(po),
    .PI(pi_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b));

  bist_tester #(.PI_W(8), .PO_W(1), .NPAT(18), .FLUSH(0), .LAT(0),
                .SEED(8'h00), .GOLDEN(16'hCF9C)) u_dut_c (
    .CK(ck), .RSTN(rstn), .START(start), .PO(po),
    .PI(pi_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .SIG(sig_c));

  function automatic exp_t zero_e();
    exp_t e;
    e.pi = 8'h00; e.busy = 1'b0; e.done = 1'b0; e.pass = 1'b0;
    e.chk_sig = 1'b1; e.sig = 16'h0000;
    return e;
  endfunction

  // Expected outputs of configuration dut in cycle j after the START edge
  function automatic exp_t mk(input int dut, input int j, input logic p);
    exp_t e;
    int len;
    logic [15:0] fsig;
    case (dut)
      0:       begin len = 9;  fsig = 16'h003F; end
      1:       begin len = 7;  fsig = 16'h000F; end
      default: begin len = 18; fsig = 16'hCF9C; end
    endcase
    e.busy = (j < len);
    e.done = (j >= len);
    e.pi = 8'h00;
    if (j < len) begin
      case (dut)
        0:       e.pi = tab_a[j];
        1:       e.pi = tab_b[j];
        default: e.pi = tab_c[j];
      endcase
    end
    e.pass    = e.done && p;
    e.chk_sig = e.done || !p;
    e.sig     = p ? fsig : 16'h0000;
    return e;
  endfunction

  task automatic push(input exp_t ea, input exp_t eb, input exp_t ec);
    ent_t t;
    t.id = n_id;
    t.a = ea; t.b = eb; t.c = ec;
    n_id = n_id + 1;
    q.push_back(t);
  endtask

  task automatic push_zero();
    push(zero_e(), zero_e(), zero_e());
  endtask

  task automatic cmp(input string nm, input string fld, input int id,
                     input logic [15:0] got, input logic [15:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_errors = n_errors + 1;
      $display("FAIL %s.%s entry %0d: got %h expected %h", nm, fld, id, got, want);
    end
  endtask

  task automatic chk(input string nm, input int id, input logic [7:0] pi,
                     input logic busy, input logic done, input logic pass,
                     input logic [15:0] sig, input exp_t e);
    cmp(nm, "pi",   id, {8'h00, pi},    {8'h00, e.pi});
    cmp(nm, "busy", id, {15'h0, busy},  {15'h0, e.busy});
    cmp(nm, "done", id, {15'h0, done},  {15'h0, e.done});
    cmp(nm, "pass", id, {15'h0, pass},  {15'h0, e.pass});
    if (e.chk_sig) cmp(nm, "sig", id, sig, e.sig);
  endtask

  // Monitor: one expectation entry per cycle, compared mid-cycle
  always @(negedge ck) begin
    ent_t t;
    if (q.size() > 0) begin
      t = q.pop_front();
      chk("A", t.id, {4'h0, pi_a}, busy_a, done_a, pass_a, sig_a, t.a);
      chk("B", t.id, {4'h0, pi_b}, busy_b, done_b, pass_b, sig_b, t.b);
      chk("C", t.id, pi_c,         busy_c, done_c, pass_c, sig_c, t.c);
    end
  end

  // One run: START pulse, then ncyc cycles of expectations; optional extra
  // START pulse while busy, optional asynchronous reset at cycle abort_j.
  task automatic run(input logic p, input int ncyc, input int pulse_j, input int abort_j);
    @(posedge ck); #1;
    po = p;
    start = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge ck); #1;
      start = (j == pulse_j);
      if (j == abort_j) begin
        rstn = 1'b0;
        push_zero();
        break;
      end else begin
        push(mk(0, j, p), mk(1, j, p), mk(2, j, p));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    po = 1'b0;
    repeat (2) begin @(posedge ck); #1; push_zero(); end
    rstn = 1'b1;
    repeat (10) begin @(posedge ck); #1; push_zero(); end

    run(1'b1, 20, -1, -1);
    run(1'b0, 20, 4, -1);
    run(1'b1, 20, -1, 5);
    repeat (2) begin @(posedge ck); #1; push_zero(); end
    @(posedge ck); #1;
    rstn = 1'b1;
    push_zero();
    repeat (2) begin @(posedge ck); #1; push_zero(); end
    run(1'b1, 20, -1, -1);

    @(negedge ck); #1;
    n_checks = n_checks + 1;
    if (q.size() != 0) begin
      n_errors = n_errors + 1;
      $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
